// File: rtl/clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_gate_ctrl
// Purpose  : Enable sequencer for the LCB/BUFGCE clock gate. Gates the
//            downstream clock after a programmable idle period or on a
//            software request, and wakes it on activity or force. Enforces a
//            minimum off time and a settle delay before reporting ready.
//            All outputs are registered, so en is glitch-free at the CE pin.
// Options  : CLOCK_GATE_CTRL_STATS_EN - builds the gate_events/gated_cycles
//            statistics counters. Without it, both ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module clock_gate_ctrl #(
    parameter int IDLE_W         = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int MIN_OFF_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              activity,
    input  logic              force_on,
    input  logic              sw_gate,
    input  logic [IDLE_W-1:0] idle_limit,
    output logic              en,
    output logic              clk_ready,
    output logic              gated,
    output logic [31:0]       gate_events,
    output logic [31:0]       gated_cycles
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int OFF_W    = $clog2(MIN_OFF_CYCLES + 1);

    localparam logic [SETTLE_W-1:0] C_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] C_SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [OFF_W-1:0]    C_OFF_MAX     = OFF_W'(MIN_OFF_CYCLES);
    localparam logic [OFF_W-1:0]    C_OFF_LAST    = OFF_W'(MIN_OFF_CYCLES - 1);
    localparam logic [OFF_W-1:0]    C_OFF_ONE     = OFF_W'(1);
    localparam logic [IDLE_W-1:0]   C_IDLE_ONE    = IDLE_W'(1);
    localparam logic [IDLE_W:0]     C_IDLE_ONE_X  = (IDLE_W+1)'(1);

    typedef enum logic [1:0] {
        ST_WAKE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OFF   = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q,   idle_cnt_d;
    logic [OFF_W-1:0]    off_cnt_q,    off_cnt_d;
    logic                wake_pend_q,  wake_pend_d;
    logic                en_q, clk_ready_q, gated_q;

    logic w_idle;
    logic w_limit_hit;
    logic w_gate_entry;

    assign w_idle = !activity && !force_on;

    // Widened compare so idle_cnt+1 cannot wrap when the counter is saturated.
    assign w_limit_hit = (idle_limit != '0) &&
                         (({1'b0, idle_cnt_q} + C_IDLE_ONE_X) >= {1'b0, idle_limit});

    // Next-state and counter updates for the gating sequencer.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        off_cnt_d    = off_cnt_q;
        wake_pend_d  = wake_pend_q;
        w_gate_entry = 1'b0;

        case (state_q)
            ST_WAKE: begin
                if (settle_cnt_q == C_SETTLE_LAST) begin
                    state_d      = ST_RUN;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + C_SETTLE_ONE;
                end
            end

            ST_RUN: begin
                if (w_idle) begin
                    idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + C_IDLE_ONE;
                end else begin
                    idle_cnt_d = '0;
                end
                // A busy cycle beats sw_gate; the pulse is simply dropped.
                if (w_idle && (w_limit_hit || sw_gate)) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (w_idle) begin
                    state_d      = ST_OFF;
                    off_cnt_d    = '0;
                    w_gate_entry = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end
            end

            ST_OFF: begin
                off_cnt_d = (off_cnt_q == C_OFF_MAX) ? off_cnt_q : off_cnt_q + C_OFF_ONE;
                // Wake requests seen before the minimum off time are latched.
                if ((wake_pend_q || !w_idle) && (off_cnt_q >= C_OFF_LAST)) begin
                    state_d      = ST_WAKE;
                    wake_pend_d  = 1'b0;
                    settle_cnt_d = '0;
                end else if (!w_idle) begin
                    wake_pend_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_WAKE;
            end
        endcase
    end

    // State, counters and registered output decode; reset keeps the clock running.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_WAKE;
            settle_cnt_q <= '0;
            idle_cnt_q   <= '0;
            off_cnt_q    <= '0;
            wake_pend_q  <= 1'b0;
            en_q         <= 1'b1;
            clk_ready_q  <= 1'b0;
            gated_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            off_cnt_q    <= off_cnt_d;
            wake_pend_q  <= wake_pend_d;
            en_q         <= (state_d != ST_OFF);
            clk_ready_q  <= (state_d == ST_RUN);
            gated_q      <= (state_d == ST_OFF);
        end
    end

    assign en        = en_q;
    assign clk_ready = clk_ready_q;
    assign gated     = gated_q;

`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic [31:0] gate_events_q;
    logic [31:0] gated_cycles_q;

    // Saturating statistics: OFF entries and cycles spent in OFF.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            gate_events_q  <= '0;
            gated_cycles_q <= '0;
        end else begin
            if (w_gate_entry && (gate_events_q != '1)) begin
                gate_events_q <= gate_events_q + 32'd1;
            end
            if ((state_q == ST_OFF) && (gated_cycles_q != '1)) begin
                gated_cycles_q <= gated_cycles_q + 32'd1;
            end
        end
    end

    assign gate_events  = gate_events_q;
    assign gated_cycles = gated_cycles_q;
`else
    assign gate_events  = 32'd0;
    assign gated_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_gate_ctrl
// Purpose  : Self-checking bench for clock_gate_ctrl. Directed scenarios plus
//            randomized traffic, compared every cycle with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_gate_ctrl;

    localparam int IDLE_W         = 16;
    localparam int SETTLE_CYCLES  = 4;
    localparam int MIN_OFF_CYCLES = 2;

    localparam int M_WAKE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_OFF   = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              activity;
    logic              force_on;
    logic              sw_gate;
    logic [IDLE_W-1:0] idle_limit;
    logic              en;
    logic              clk_ready;
    logic              gated;
    logic [31:0]       gate_events;
    logic [31:0]       gated_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          m_mode;
    int          m_settle;
    longint      m_idle;
    int          m_off;
    bit          m_pend;
    longint      m_gev;
    longint      m_gcyc;

    clock_gate_ctrl #(
        .IDLE_W         (IDLE_W),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .MIN_OFF_CYCLES (MIN_OFF_CYCLES)
    ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .activity     (activity),
        .force_on     (force_on),
        .sw_gate      (sw_gate),
        .idle_limit   (idle_limit),
        .en           (en),
        .clk_ready    (clk_ready),
        .gated        (gated),
        .gate_events  (gate_events),
        .gated_cycles (gated_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference model, using the inputs sampled at this edge.
    task automatic model_step();
        bit idle_c;
        longint lim;
        if (!resetn) begin
            m_mode = M_WAKE; m_settle = 0; m_idle = 0; m_off = 0; m_pend = 0;
            m_gev = 0; m_gcyc = 0;
            return;
        end
        idle_c = !activity && !force_on;
        lim    = longint'(idle_limit);
        case (m_mode)
            M_WAKE: begin
                if (m_settle + 1 >= SETTLE_CYCLES) begin
                    m_mode = M_RUN; m_settle = 0;
                end else begin
                    m_settle++;
                end
            end
            M_RUN: begin
                bit go;
                go = idle_c && ((lim != 0 && m_idle + 1 >= lim) || sw_gate);
                if (idle_c) m_idle = (m_idle >= 65535) ? 65535 : m_idle + 1;
                else        m_idle = 0;
                if (go) m_mode = M_DRAIN;
            end
            M_DRAIN: begin
                if (idle_c) begin
                    m_mode = M_OFF; m_off = 0;
                    if (m_gev < 64'hFFFF_FFFF) m_gev++;
                end else begin
                    m_mode = M_RUN; m_idle = 0;
                end
            end
            default: begin
                if (m_gcyc < 64'hFFFF_FFFF) m_gcyc++;
                if ((m_pend || !idle_c) && m_off + 1 >= MIN_OFF_CYCLES) begin
                    m_mode = M_WAKE; m_pend = 0; m_settle = 0;
                end else if (!idle_c) begin
                    m_pend = 1;
                end
                if (m_off < MIN_OFF_CYCLES) m_off++;
            end
        endcase
    endtask

    // Advance one clock, update the model, then compare after the edge settles.
    task automatic tick();
        logic [31:0] exp_ev, exp_cy;
        @(posedge clk);
        model_step();
        #1;
`ifdef CLOCK_GATE_CTRL_STATS_EN
        exp_ev = m_gev[31:0];
        exp_cy = m_gcyc[31:0];
`else
        exp_ev = 32'd0;
        exp_cy = 32'd0;
`endif
        check("en",           {31'd0, en},        {31'd0, m_mode != M_OFF});
        check("clk_ready",    {31'd0, clk_ready}, {31'd0, m_mode == M_RUN});
        check("gated",        {31'd0, gated},     {31'd0, m_mode == M_OFF});
        check("gate_events",  gate_events,        exp_ev);
        check("gated_cycles", gated_cycles,       exp_cy);
    endtask

    task automatic drive(input bit a, input bit f, input bit s, input int lim);
        activity   = a;
        force_on   = f;
        sw_gate    = s;
        idle_limit = IDLE_W'(lim);
    endtask

    // Tick with current inputs until the model reaches a mode; bounded.
    task automatic wait_mode(input int mode, input int budget, input string tag);
        int n = 0;
        while (m_mode != mode && n < budget) begin
            tick();
            n++;
        end
        check({"reach_", tag}, {31'd0, m_mode == mode}, 32'd1);
    endtask

    initial begin
        m_mode = M_WAKE; m_settle = 0; m_idle = 0; m_off = 0; m_pend = 0;
        m_gev = 0; m_gcyc = 0;
        resetn = 1'b0;
        drive(0, 0, 0, 0);
        #1;

        // Reset held three cycles, then settle into RUN
        repeat (3) tick();
        resetn = 1'b1;
        drive(1, 0, 0, 0);
        repeat (8) tick();

        // Auto-gate at idle_limit=3, then short wake pulse on first OFF cycle
        drive(0, 0, 0, 3);
        wait_mode(M_OFF, 20, "off_auto");
        drive(1, 0, 0, 3);
        tick();
        drive(0, 0, 0, 3);
        repeat (10) tick();

        // sw_gate colliding with activity is dropped; sw_gate alone gates
        drive(1, 0, 0, 0);
        wait_mode(M_RUN, 20, "run_sw");
        drive(1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        repeat (4) tick();
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        repeat (4) tick();

        // Abort in DRAIN
        drive(1, 0, 0, 2);
        wait_mode(M_RUN, 20, "run_abort");
        drive(0, 0, 0, 2);
        wait_mode(M_DRAIN, 20, "drain_abort");
        drive(1, 0, 0, 2);
        tick();
        drive(0, 1, 0, 1);
        repeat (100) tick();

        // Reset asserted for one cycle while OFF
        drive(0, 0, 0, 1);
        wait_mode(M_OFF, 20, "off_rst");
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (8) tick();

        // Randomized traffic
        for (int blk = 0; blk < 60; blk++) begin
            int p_act = $urandom_range(0, 60);
            int p_frc = ($urandom_range(0, 3) == 0) ? 30 : 0;
            int lim   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 8);
            for (int c = 0; c < 50; c++) begin
                if ($urandom_range(0, 19) == 0) lim = $urandom_range(0, 8);
                drive($urandom_range(0, 99) < p_act,
                      $urandom_range(0, 99) < p_frc,
                      $urandom_range(0, 11) == 0,
                      lim);
                resetn = ($urandom_range(0, 399) != 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
